// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
//   slave  : arbiter side (takes requests and mem_dout, drives grants, read returns, memory controls)
//   master : environment side (requesters plus the memory)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    // Requester port 0
    logic                  req0;
    logic                  we0;
    logic                  lock0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Requester port 1
    logic                  req1;
    logic                  we1;
    logic                  lock1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    // Single-port synchronous memory
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_dout,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_dout,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port synchronous memory,
// with an ownership lock for atomic read-modify-write sequences.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: req/we/lock/addr/wdata and gnt/rvalid/rdata
//          per requester, plus mem_en/mem_we/mem_addr/mem_din/mem_dout
// Grants are decided in the same cycle as the request, so gnt and the memory
// controls are combinational; rvalid is a registered strobe one cycle later.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   last_q, last_d;          // 1 = port 1 was granted last
    logic   rd_pend0_q, rd_pend0_d;
    logic   rd_pend1_q, rd_pend1_d;

    logic                  gnt0;
    logic                  gnt1;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] din_sel;

    // Grant selection; nothing is granted while in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (owner_q)
                FREE: begin
                    if (bus.req0 && bus.req1) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
                end
                OWN0:    gnt0 = bus.req0;
                OWN1:    gnt1 = bus.req1;
                default: ;
            endcase
        end
    end

    // Next state: ownership follows the lock bit of each granted access
    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        rd_pend0_d = gnt0 && !bus.we0;
        rd_pend1_d = gnt1 && !bus.we1;
        if (gnt0) begin
            last_d  = 1'b0;
            owner_d = bus.lock0 ? OWN0 : FREE;
        end else if (gnt1) begin
            last_d  = 1'b1;
            owner_d = bus.lock1 ? OWN1 : FREE;
        end
    end

    // Memory port mux; address/data are don't-care when mem_en is low
    always_comb begin
        addr_sel = gnt1 ? bus.addr1  : bus.addr0;
        din_sel  = gnt1 ? bus.wdata1 : bus.wdata0;
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_en   = gnt0 || gnt1;
    assign bus.mem_we   = (gnt0 && bus.we0) || (gnt1 && bus.we1);
    assign bus.mem_addr = addr_sel;
    assign bus.mem_din  = din_sel;

    // A read issued just before reset must not return during the reset cycle
    assign bus.rvalid0  = rd_pend0_q && !rst;
    assign bus.rvalid1  = rd_pend1_q && !rst;
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= FREE;
            last_q     <= 1'b1;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory, a reference copy
// of memory contents, and per-port queues of expected read returns.
module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           due;
        logic [7:0]   data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         wr_count = 0;
    int         cyc      = 0;
    int         n_tests  = 0;
    int         n_fail   = 0;

    // Behavioural single-port memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_din;
                wr_count          <= wr_count + 1;
            end else begin
                bus.mem_dout <= mem[bus.mem_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Read-return scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        n_tests++;
        if (bus.rvalid0 && bus.rvalid1) begin
            n_fail++;
            $display("FAIL rvalid_both: rvalid0=%b rvalid1=%b, required at most one", bus.rvalid0, bus.rvalid1);
        end
        if (bus.rvalid0) begin
            n_tests++;
            if (q0.size() == 0 || q0[0].due != cyc) begin
                n_fail++;
                $display("FAIL rvalid0_unexpected: rvalid0=1 at cycle %0d, no read due", cyc);
            end else begin
                if (bus.rdata0 !== q0[0].data) begin
                    n_fail++;
                    $display("FAIL rdata0: got %h, required %h", bus.rdata0, q0[0].data);
                end
                q0.delete(0);
            end
        end else if (q0.size() != 0 && q0[0].due == cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid0_missing: rvalid0=0 at cycle %0d, required 1", cyc);
            q0.delete(0);
        end
        if (bus.rvalid1) begin
            n_tests++;
            if (q1.size() == 0 || q1[0].due != cyc) begin
                n_fail++;
                $display("FAIL rvalid1_unexpected: rvalid1=1 at cycle %0d, no read due", cyc);
            end else begin
                if (bus.rdata1 !== q1[0].data) begin
                    n_fail++;
                    $display("FAIL rdata1: got %h, required %h", bus.rdata1, q1[0].data);
                end
                q1.delete(0);
            end
        end else if (q1.size() != 0 && q1[0].due == cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid1_missing: rvalid1=0 at cycle %0d, required 1", cyc);
            q1.delete(0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    // Feed the scoreboard from the accesses accepted this cycle
    task automatic observe();
        if (bus.gnt0) begin
            if (bus.we0) ref_mem[bus.addr0] = bus.wdata0;
            else q0.push_back('{due: cyc + 1, data: ref_mem[bus.addr0]});
        end
        if (bus.gnt1) begin
            if (bus.we1) ref_mem[bus.addr1] = bus.wdata1;
            else q1.push_back('{due: cyc + 1, data: ref_mem[bus.addr1]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h01; bus.wdata0 = 8'hEE;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: gnt0 gnt1 en we rv0 rv1 = %b, required 000000",
                         {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1});
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_single_reads();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== {4'b1011, 8'h10, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_write: gnt0 gnt1 en we=%b addr=%h din=%h, required 1011 10 a5",
                     {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_din);
        end
        observe();
        next_cycle();
        idle_inputs();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b0110, 8'h10}) begin
            n_fail++;
            $display("FAIL single_read_gnt: gnt0 gnt1 en we=%b addr=%h, required 0110 10",
                     {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        observe();
        next_cycle();
        idle_inputs();
        #1;
        n_tests++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata1} !== {2'b01, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_read_data: rvalid0=%b rvalid1=%b rdata1=%h, required 0 1 a5",
                     bus.rvalid0, bus.rvalid1, bus.rdata1);
        end
        next_cycle();
    endtask

    task automatic test_raw_wrap();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'hFF; bus.wdata0 = 8'h3C;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.mem_we, bus.mem_addr, bus.mem_din} !== {2'b11, 8'hFF, 8'h3C}) begin
            n_fail++;
            $display("FAIL raw_write: gnt0=%b we=%b addr=%h din=%h, required 1 1 ff 3c",
                     bus.gnt0, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        observe();
        next_cycle();
        idle_inputs();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'hFF;
        #1;
        n_tests++;
        if ({bus.gnt1, bus.mem_we, bus.mem_addr} !== {2'b10, 8'hFF}) begin
            n_fail++;
            $display("FAIL raw_read_gnt: gnt1=%b we=%b addr=%h, required 1 0 ff", bus.gnt1, bus.mem_we, bus.mem_addr);
        end
        observe();
        next_cycle();
        idle_inputs();
        #1;
        n_tests++;
        if ({bus.rvalid1, bus.rdata1} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL raw_read_data: rvalid1=%b rdata1=%h, required 1 3c", bus.rvalid1, bus.rdata1);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            logic       exp0;
            logic [7:0] exp_addr;
            exp0     = (i % 2 == 0);
            exp_addr = exp0 ? 8'h10 : 8'hFF;
            #1;
            n_tests++;
            if ({bus.gnt0, bus.gnt1, bus.mem_addr} !== {exp0, !exp0, exp_addr}) begin
                n_fail++;
                $display("FAIL contention_%0d: gnt0=%b gnt1=%b addr=%h, required %b %b %h",
                         i, bus.gnt0, bus.gnt1, bus.mem_addr, exp0, !exp0, exp_addr);
            end
            observe();
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lock();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h11;
        #1;
        observe();
        next_cycle();
        // Port 1 takes the lock with a read while port 0 also requests
        bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1; bus.addr1 = 8'h20;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_take: gnt0=%b gnt1=%b, required 0 1", bus.gnt0, bus.gnt1);
        end
        observe();
        next_cycle();
        bus.req1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if ({bus.gnt0, bus.gnt1, bus.mem_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL lock_hold_%0d: gnt0=%b gnt1=%b en=%b, required 0 0 0", i, bus.gnt0, bus.gnt1, bus.mem_en);
            end
            observe();
            next_cycle();
        end
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.wdata1 = 8'h5A;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_we} !== 3'b011) begin
            n_fail++;
            $display("FAIL lock_release: gnt0=%b gnt1=%b we=%b, required 0 1 1", bus.gnt0, bus.gnt1, bus.mem_we);
        end
        observe();
        next_cycle();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1, bus.mem_addr} !== {2'b10, 8'h20}) begin
            n_fail++;
            $display("FAIL lock_after: gnt0=%b gnt1=%b addr=%h, required 1 0 20", bus.gnt0, bus.gnt1, bus.mem_addr);
        end
        observe();
        next_cycle();
        idle_inputs();
        #1;
        n_tests++;
        if ({bus.rvalid0, bus.rdata0} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL lock_readback: rvalid0=%b rdata0=%h, required 1 5a", bus.rvalid0, bus.rdata0);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b1; bus.addr0 = 8'h10;
        #1;
        n_tests++;
        if (bus.gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rmr_gnt0: gnt0=%b, required 1", bus.gnt0);
        end
        observe();
        next_cycle();
        // Reset cancels the outstanding read
        idle_inputs();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        n_tests++;
        if ({bus.rvalid0, bus.mem_we, bus.gnt0, bus.gnt1, bus.mem_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmr_reset: rv0 we gnt0 gnt1 en=%b, required 00000",
                     {bus.rvalid0, bus.mem_we, bus.gnt0, bus.gnt1, bus.mem_en});
        end
        next_cycle();
        // Owner must be FREE: a lone port 1 request is accepted
        rst = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
        #1;
        n_tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmr_owner_free: gnt0=%b gnt1=%b, required 0 1", bus.gnt0, bus.gnt1);
        end
        observe();
        next_cycle();
        idle_inputs();
        bus.req0 = 1'b1; bus.addr0 = 8'h10;
        #1;
        observe();
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        next_cycle();
        // last must be back at 1 so port 0 wins the first contention
        rst = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.addr1 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            logic exp0;
            exp0 = (i == 0);
            #1;
            n_tests++;
            if ({bus.gnt0, bus.gnt1} !== {exp0, !exp0}) begin
                n_fail++;
                $display("FAIL rmr_first_%0d: gnt0=%b gnt1=%b, required %b %b", i, bus.gnt0, bus.gnt1, exp0, !exp0);
            end
            observe();
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_idle();
        logic [7:0] snap [256];
        int         wc;
        int         diffs;
        snap = mem;
        wc   = wr_count;
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if ({bus.mem_en, bus.mem_we, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 6'b0) begin
                n_fail++;
                $display("FAIL idle_%0d: en we gnt0 gnt1 rv0 rv1=%b, required 000000",
                         i, {bus.mem_en, bus.mem_we, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1});
            end
            next_cycle();
        end
        diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== snap[a]) diffs++;
        n_tests++;
        if (wr_count != wc || diffs != 0) begin
            n_fail++;
            $display("FAIL idle_mem: writes=%0d changed=%0d, required 0 0", wr_count - wc, diffs);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
        next_cycle();
        test_reset();
        test_single_reads();
        test_raw_wrap();
        test_contention();
        test_lock();
        test_reset_mid_read();
        test_idle();
        n_tests++;
        if (q0.size() + q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, required 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
